pep_ks_body_ram: RTL and testbench

- Body RAM between the key-switch output stage and the blind-rotation consumer.
- Captures the key-switched BLWE body written per PID and parity (double-buffered across KS loops).
- Tracks per-entry validity, mod-switches each body to 2N on read, and returns it to the consumer with fixed latency.
- Flags overwrite, underflow and out-of-range errors.

---
 rtl/pep_ks_body_ram_pkg.sv | 30 +++
 rtl/pep_ks_body_ram_if.sv | 33 +++
 rtl/pep_ks_body_modswitch.sv | 34 +++
 rtl/pep_ks_body_ram.sv | 160 ++++++++++++++++
 tb/tb_pep_ks_body_ram.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pep_ks_body_ram_pkg.sv
// Shared parameters, error record and helpers for the key-switch body RAM.
package pep_ks_body_ram_pkg;

  localparam int OP_W        = 21;
  localparam int OUT_W       = 12;
  localparam int PID_NB      = 16;
  localparam int RAM_LATENCY = 2;
  localparam int MS_SHIFT    = OP_W - OUT_W;
  localparam int PID_IDX_W   = $clog2(PID_NB);
  // One spare PID bit so that out-of-range PIDs can be presented and flagged.
  localparam int PID_W       = PID_IDX_W + 1;
  localparam int CNT_W       = PID_W + 1;
  localparam int ADDR_W      = PID_IDX_W + 1;

  typedef struct packed {
    logic pid_oor;
    logic rd_udf;
    logic wr_ovf;
  } pep_boram_error_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [PID_NB-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < PID_NB; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/pep_ks_body_ram_if.sv
// Bus bundle between the body RAM, the key-switch writer and the BR reader.
interface pep_ks_body_ram_if;
  import pep_ks_body_ram_pkg::*;

  logic                   boram_wr_en;
  logic [OP_W-1:0]        boram_data;
  logic [PID_W-1:0]       boram_pid;
  logic                   boram_parity;
  logic                   reset_cache;
  logic                   br_boram_rd_en;
  logic [PID_W-1:0]       br_boram_rd_pid;
  logic                   br_boram_rd_parity;
  logic [OUT_W-1:0]       boram_br_rd_data;
  logic [PID_W-1:0]       boram_br_rd_pid;
  logic                   boram_br_rd_avail;
  logic [2*CNT_W-1:0]     boram_vld_cnt;
  pep_boram_error_t       boram_error;

  modport master (
    output boram_wr_en, boram_data, boram_pid, boram_parity, reset_cache,
           br_boram_rd_en, br_boram_rd_pid, br_boram_rd_parity,
    input  boram_br_rd_data, boram_br_rd_pid, boram_br_rd_avail,
           boram_vld_cnt, boram_error
  );

  modport slave (
    input  boram_wr_en, boram_data, boram_pid, boram_parity, reset_cache,
           br_boram_rd_en, br_boram_rd_pid, br_boram_rd_parity,
    output boram_br_rd_data, boram_br_rd_pid, boram_br_rd_avail,
           boram_vld_cnt, boram_error
  );

endinterface

// File: rtl/pep_ks_body_modswitch.sv
// Registered rounding right shift from IN_W to RES_W bits (mod switch to 2N).
module pep_ks_body_modswitch #(
  parameter int IN_W  = 21,
  parameter int RES_W = 12
) (
  input  logic             clk,
  input  logic             s_rst_n,
  input  logic [IN_W-1:0]  in_data,
  output logic [RES_W-1:0] out_data
);

  localparam int              SHIFT = IN_W - RES_W;
  localparam logic [IN_W:0]   ROUND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);

  logic [IN_W:0]  sum_s;
  logic [RES_W-1:0] data_d, data_q;

  // One extra bit of headroom; truncation to RES_W makes 2N wrap to 0.
  always_comb begin
    sum_s  = {1'b0, in_data} + ROUND;
    data_d = RES_W'(sum_s >> SHIFT);
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign out_data = data_q;

endmodule

// File: rtl/pep_ks_body_ram.sv
// Body RAM between key switch and blind rotation: per PID/parity storage with
// validity tracking, mod switch to 2N on read, and error pulses.
module pep_ks_body_ram
  import pep_ks_body_ram_pkg::*;
(
  input  logic             clk,
  input  logic             s_rst_n,
  pep_ks_body_ram_if.slave bus
);

  logic                   wr_en_d, wr_en_q;
  logic [OP_W-1:0]        wr_data_d, wr_data_q;
  logic [PID_W-1:0]       wr_pid_d, wr_pid_q;
  logic                   wr_par_d, wr_par_q;
  logic                   rd_en_d, rd_en_q;
  logic [PID_W-1:0]       rd_pid_d, rd_pid_q;
  logic                   rd_par_d, rd_par_q;

  logic                   wr_oor_s, rd_oor_s, wr_do_s, rd_do_s;
  logic [ADDR_W-1:0]      wr_addr_s, rd_addr_s;
  logic [2*PID_NB-1:0]    wr_mask_s, rd_mask_s;
  logic [2*PID_NB-1:0]    valid_d, valid_q;
  logic [CNT_W-1:0]       cnt0_d, cnt0_q, cnt1_d, cnt1_q;
  pep_boram_error_t       err_d, err_q;

  logic [OP_W-1:0]        mem_q [2*PID_NB];
  logic [RAM_LATENCY-1:0] pipe_vld_d, pipe_vld_q, pipe_oor_d, pipe_oor_q;
  logic [PID_W-1:0]       pipe_pid_d  [RAM_LATENCY];
  logic [PID_W-1:0]       pipe_pid_q  [RAM_LATENCY];
  logic [OP_W-1:0]        pipe_data_d [RAM_LATENCY];
  logic [OP_W-1:0]        pipe_data_q [RAM_LATENCY];
  logic                   avail_d, avail_q;
  logic [PID_W-1:0]       pid_out_d, pid_out_q;
  logic [OP_W-1:0]        ms_in_s;
  logic [OUT_W-1:0]       ms_out_s;

  always_comb begin
    wr_en_d   = bus.boram_wr_en;
    wr_data_d = bus.boram_data;
    wr_pid_d  = bus.boram_pid;
    wr_par_d  = bus.boram_parity;
    rd_en_d   = bus.br_boram_rd_en;
    rd_pid_d  = bus.br_boram_rd_pid;
    rd_par_d  = bus.br_boram_rd_parity;
  end

  // Access decode; the valid flag is sampled before this cycle's update.
  always_comb begin
    wr_oor_s  = wr_en_q && (wr_pid_q >= PID_W'(PID_NB));
    rd_oor_s  = rd_en_q && (rd_pid_q >= PID_W'(PID_NB));
    wr_do_s   = wr_en_q && !wr_oor_s;
    rd_do_s   = rd_en_q && !rd_oor_s;
    wr_addr_s = {wr_par_q, wr_pid_q[PID_IDX_W-1:0]};
    rd_addr_s = {rd_par_q, rd_pid_q[PID_IDX_W-1:0]};
    wr_mask_s = '0;
    rd_mask_s = '0;
    wr_mask_s[wr_addr_s] = wr_do_s;
    rd_mask_s[rd_addr_s] = rd_do_s;
    if (bus.reset_cache) begin
      valid_d = '0;
    end else begin
      valid_d = (valid_q & ~rd_mask_s) | wr_mask_s;
    end
    cnt0_d        = popcount(valid_d[PID_NB-1:0]);
    cnt1_d        = popcount(valid_d[2*PID_NB-1:PID_NB]);
    err_d.pid_oor = wr_oor_s | rd_oor_s;
    err_d.rd_udf  = rd_do_s & ~valid_q[rd_addr_s];
    err_d.wr_ovf  = wr_do_s & valid_q[wr_addr_s];
  end

  // Read pipe: RAM latency stages carrying strobe, PID echo and the oor squash.
  always_comb begin
    pipe_vld_d = '0;
    pipe_oor_d = '0;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      if (i == 0) begin
        pipe_vld_d[i]  = rd_en_q;
        pipe_oor_d[i]  = rd_oor_s;
        pipe_pid_d[i]  = rd_pid_q;
        pipe_data_d[i] = mem_q[rd_addr_s];
      end else begin
        pipe_vld_d[i]  = pipe_vld_q[i-1];
        pipe_oor_d[i]  = pipe_oor_q[i-1];
        pipe_pid_d[i]  = pipe_pid_q[i-1];
        pipe_data_d[i] = pipe_data_q[i-1];
      end
    end
    ms_in_s   = pipe_oor_q[RAM_LATENCY-1] ? '0 : pipe_data_q[RAM_LATENCY-1];
    avail_d   = pipe_vld_q[RAM_LATENCY-1];
    pid_out_d = pipe_pid_q[RAM_LATENCY-1];
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      wr_pid_q   <= '0;
      wr_par_q   <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_pid_q   <= '0;
      rd_par_q   <= 1'b0;
      valid_q    <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      err_q      <= '0;
      pipe_vld_q <= '0;
      pipe_oor_q <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_pid_q[i]  <= '0;
        pipe_data_q[i] <= '0;
      end
      avail_q    <= 1'b0;
      pid_out_q  <= '0;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      wr_pid_q   <= wr_pid_d;
      wr_par_q   <= wr_par_d;
      rd_en_q    <= rd_en_d;
      rd_pid_q   <= rd_pid_d;
      rd_par_q   <= rd_par_d;
      valid_q    <= valid_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      err_q      <= err_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_oor_q <= pipe_oor_d;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_pid_q[i]  <= pipe_pid_d[i];
        pipe_data_q[i] <= pipe_data_d[i];
      end
      avail_q    <= avail_d;
      pid_out_q  <= pid_out_d;
    end
  end

  // Storage array is deliberately unreset; the read above is read-first.
  always_ff @(posedge clk) begin
    if (wr_do_s) begin
      mem_q[wr_addr_s] <= wr_data_q;
    end
  end

  pep_ks_body_modswitch #(
    .IN_W  (OP_W),
    .RES_W (OUT_W)
  ) u_modswitch (
    .clk      (clk),
    .s_rst_n  (s_rst_n),
    .in_data  (ms_in_s),
    .out_data (ms_out_s)
  );

  assign bus.boram_br_rd_data  = ms_out_s;
  assign bus.boram_br_rd_pid   = pid_out_q;
  assign bus.boram_br_rd_avail = avail_q;
  assign bus.boram_vld_cnt     = {cnt1_q, cnt0_q};
  assign bus.boram_error       = err_q;

endmodule

// File: tb/tb_pep_ks_body_ram.sv
// Scoreboard bench for pep_ks_body_ram: directed cases plus random traffic
// against a per-edge behavioural model of the RAM, valid flags and errors.
module tb_pep_ks_body_ram;
  import pep_ks_body_ram_pkg::*;

  logic clk = 1'b0;
  logic s_rst_n = 1'b0;
  always #5 clk = ~clk;

  pep_ks_body_ram_if bus ();
  pep_ks_body_ram dut (.clk(clk), .s_rst_n(s_rst_n), .bus(bus));

  typedef struct {
    int pid;
    int data;
    bit known;
    int cyc;
  } exp_rd_t;

  exp_rd_t rd_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  bit vld_m   [2][PID_NB];
  int mem_m   [2][PID_NB];
  bit known_m [2][PID_NB];
  int exp_err [8];
  int exp_cnt [8];
  bit p_wr, p_rd;
  int p_wpid, p_wpar, p_wdata, p_rpid, p_rpar;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  function automatic int modsw(input int d);
    return ((d + (1 << (MS_SHIFT - 1))) >> MS_SHIFT) % (1 << OUT_W);
  endfunction

  function automatic int bank_cnt(input int b);
    int c = 0;
    for (int i = 0; i < PID_NB; i++) c += vld_m[b][i];
    return c;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < PID_NB; i++) vld_m[b][i] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_err[i] = 0;
      exp_cnt[i] = 0;
    end
    p_wr = 1'b0;
    p_rd = 1'b0;
  endtask

  // Drive one cycle of inputs; model the edge at which last cycle's accesses land.
  task automatic step(input bit wr, input int wpid, input int wpar, input int wdata,
                      input bit rd, input int rpid, input int rpar, input bit rc);
    bit woor, roor;
    int e;
    @(posedge clk);
    #1;
    bus.boram_wr_en        = wr;
    bus.boram_pid          = PID_W'(wpid);
    bus.boram_parity       = wpar[0];
    bus.boram_data         = OP_W'(wdata);
    bus.br_boram_rd_en     = rd;
    bus.br_boram_rd_pid    = PID_W'(rpid);
    bus.br_boram_rd_parity = rpar[0];
    bus.reset_cache        = rc;
    woor = p_wr && (p_wpid >= PID_NB);
    roor = p_rd && (p_rpid >= PID_NB);
    e = 0;
    if (woor || roor) e |= 4;
    if (p_rd && !roor && !vld_m[p_rpar][p_rpid]) e |= 2;
    if (p_wr && !woor && vld_m[p_wpar][p_wpid]) e |= 1;
    if (p_rd && roor) rd_q.push_back('{p_rpid, 0, 1'b1, cyc + 3});
    if (p_rd && !roor)
      rd_q.push_back('{p_rpid, modsw(mem_m[p_rpar][p_rpid]), known_m[p_rpar][p_rpid], cyc + 3});
    if (p_rd && !roor) vld_m[p_rpar][p_rpid] = 1'b0;
    if (p_wr && !woor) begin
      vld_m[p_wpar][p_wpid]   = 1'b1;
      mem_m[p_wpar][p_wpid]   = p_wdata;
      known_m[p_wpar][p_wpid] = 1'b1;
    end
    if (rc)
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < PID_NB; i++) vld_m[b][i] = 1'b0;
    exp_err[(cyc + 1) % 8] = e;
    exp_cnt[(cyc + 1) % 8] = (bank_cnt(1) << CNT_W) | bank_cnt(0);
    p_wr = wr; p_wpid = wpid; p_wpar = wpar; p_wdata = wdata;
    p_rd = rd; p_rpid = rpid; p_rpar = rpar;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int pid, input int par, input int data);
    step(1, pid, par, data, 0, 0, 0, 0);
  endtask

  task automatic rd(input int pid, input int par);
    step(0, 0, 0, 0, 1, pid, par, 0);
  endtask

  // Monitor: per-cycle error/count checks and scoreboard pops on avail.
  initial begin
    exp_rd_t ex;
    logic [2:0] got_err;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        got_err = bus.boram_error;
        chk("boram_error", {29'd0, got_err}, exp_err[cyc % 8]);
        chk("vld_cnt", {20'd0, bus.boram_vld_cnt}, exp_cnt[cyc % 8]);
      end
      if (bus.boram_br_rd_avail !== 1'b0) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_avail", {31'd0, bus.boram_br_rd_avail}, 0);
        end else begin
          ex = rd_q.pop_front();
          chk("avail_cycle", cyc, ex.cyc);
          chk("rd_pid", {27'd0, bus.boram_br_rd_pid}, ex.pid);
          if (ex.known) chk("rd_data", {20'd0, bus.boram_br_rd_data}, ex.data);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    bus.boram_wr_en = 1'b0; bus.boram_pid = '0; bus.boram_parity = 1'b0;
    bus.boram_data = '0; bus.br_boram_rd_en = 1'b0; bus.br_boram_rd_pid = '0;
    bus.br_boram_rd_parity = 1'b0; bus.reset_cache = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_avail", {31'd0, bus.boram_br_rd_avail}, 0);
    chk("rst_data", {20'd0, bus.boram_br_rd_data}, 0);
    chk("rst_pid", {27'd0, bus.boram_br_rd_pid}, 0);
    chk("rst_vld_cnt", {20'd0, bus.boram_vld_cnt}, 0);
    chk("rst_error", {29'd0, bus.boram_error}, 0);
    s_rst_n = 1'b1;
    idle(1);
    chk_en = 1'b1;

    wr(3, 0, 32'h000100); idle(1); rd(3, 0); idle(5);
    wr(5, 1, 32'h1FFFFF); idle(1); rd(5, 1); idle(1);
    wr(5, 1, 32'h0000FF); idle(1); rd(5, 1); idle(1);
    wr(5, 1, 32'h1FFEFF); idle(1); rd(5, 1); idle(5);
    wr(7, 0, 32'h012345); idle(1); wr(7, 0, 32'h0ABCDE); idle(1); rd(7, 0); idle(5);
    rd(9, 0); idle(5);
    step(1, 2, 1, 32'h155555, 1, 2, 1, 0); idle(1); rd(2, 1); idle(5);
    for (int i = 0; i < 5; i++) begin
      wr(i, 0, 32'h001000 * (i + 1));
      wr(i + 8, 1, 32'h000777 + i);
    end
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 1); idle(2);
    wr(20, 0, 32'h00FFFF); idle(1); rd(20, 1); rd(31, 0); idle(5);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 17), $urandom_range(0, 1),
           $urandom_range(0, 32'h1FFFFF), $urandom_range(0, 1), $urandom_range(0, 17),
           $urandom_range(0, 1), ($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 20 && rd_q.size() != 0; i++) idle(1);
    chk("drain_pending", rd_q.size(), 0);

    idle(1); rd(3, 0); idle(1);
    #3;
    s_rst_n = 1'b0;
    chk_en  = 1'b0;
    rd_q.delete();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    s_rst_n = 1'b1;
    idle(1);
    chk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_reset_avail", {31'd0, bus.boram_br_rd_avail}, 0);
    end
    wr(4, 1, 32'h000300); idle(1); rd(4, 1); idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
